// File: rtl/chan_packer_if.sv
// Packer stream interface: narrow input handshake plus packed output handshake.
// The slave modport is the packer's view, the master modport is the producer/sink side.
interface chan_packer_if #(
  parameter int g_w_in  = 8,
  parameter int g_ratio = 4,
  parameter int g_cw    = $clog2(g_ratio + 1)
);
  logic                       in_valid;
  logic                       in_ready;
  logic [g_w_in-1:0]          in_data;
  logic                       in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [g_w_in*g_ratio-1:0]  out_data;
  logic [g_cw-1:0]            out_cnt;
  logic                       out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_cnt, out_last
  );
endinterface

// File: rtl/chan_packer.sv
// chan_packer: packs g_ratio narrow input words (LSB slot first) into one wide
// output word. Optional early completion on in_last is enabled by defining
// CHAN_PACKER_FLUSH_EN; without it in_last is ignored and out_last stays 0.
//
// state | meaning
// ------+----------------------------------------------------------------
// FILL  | collecting input words into slots; in_ready=1, out_valid=0
// HOLD  | completed word presented; in_ready follows out_ready so a new
//       | word can start in slot 0 on the same cycle the old one leaves
module chan_packer #(
  parameter int g_w_in  = 8,
  parameter int g_ratio = 4,
  parameter int g_cw    = $clog2(g_ratio + 1)
) (
  input logic           clk,
  input logic           rst,
  chan_packer_if.slave  bus
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  localparam int IW = (g_ratio > 1) ? $clog2(g_ratio) : 1;
  localparam int DW = g_w_in * g_ratio;
  localparam logic [IW-1:0] LAST_SLOT = IW'(g_ratio - 1);

  state_t           state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt, slot;
  logic [DW-1:0]    data_r, data_nxt;
  logic [g_cw-1:0]  cnt_r, cnt_nxt;
  logic             last_r, last_nxt;
  logic             in_xfer, out_xfer, flush_last, complete;

`ifdef CHAN_PACKER_FLUSH_EN
  assign flush_last = bus.in_last;
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign flush_last     = 1'b0;
`endif

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;
  // In HOLD an accepted word always starts a fresh output word in slot 0.
  assign slot     = (state == FILL) ? idx : '0;
  assign complete = in_xfer && ((slot == LAST_SLOT) || flush_last);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      idx    <= '0;
      data_r <= '0;
      cnt_r  <= '0;
      last_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      data_r <= data_nxt;
      cnt_r  <= cnt_nxt;
      last_r <= last_nxt;
    end
  end

  // Next-state: drain the presented word, then merge any accepted input word.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    data_nxt  = data_r;
    cnt_nxt   = cnt_r;
    last_nxt  = last_r;
    if (out_xfer) begin
      state_nxt = FILL;
      data_nxt  = '0;
      cnt_nxt   = '0;
      last_nxt  = 1'b0;
    end
    if (in_xfer) begin
      for (int k = 0; k < g_ratio; k++) begin
        if (slot == IW'(k)) data_nxt[k*g_w_in +: g_w_in] = bus.in_data;
      end
      if (complete) begin
        state_nxt = HOLD;
        idx_nxt   = '0;
        cnt_nxt   = g_cw'(slot) + g_cw'(1);
        last_nxt  = flush_last;
      end else begin
        state_nxt = FILL;
        idx_nxt   = slot + IW'(1);
      end
    end
  end

  // Outputs: handshake decode from state, registered word passed through.
  always_comb begin
    bus.out_valid = (state == HOLD);
    if (rst)                bus.in_ready = 1'b0;
    else if (state == FILL) bus.in_ready = 1'b1;
    else                    bus.in_ready = bus.out_ready;
    bus.out_data = data_r;
    bus.out_cnt  = cnt_r;
    bus.out_last = last_r;
  end

endmodule

// File: tb/tb_chan_packer.sv
// Testbench for chan_packer: directed scenarios plus randomized traffic checked
// against a word-level scoreboard. Honours CHAN_PACKER_FLUSH_EN when defined.
module tb_chan_packer;
  localparam int W  = 8;
  localparam int R  = 4;
  localparam int DW = W * R;

`ifdef CHAN_PACKER_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chan_packer_if #(.g_w_in(W), .g_ratio(R)) a_if ();
  chan_packer_if #(.g_w_in(W), .g_ratio(1)) b_if ();

  chan_packer #(.g_w_in(W), .g_ratio(R)) dut   (.clk(clk), .rst(rst), .bus(a_if.slave));
  chan_packer #(.g_w_in(W), .g_ratio(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            cnt;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] acc   = '0;
  int            acc_n = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: a completed word is pending exactly while the packer should be in HOLD.
  always @(negedge clk) begin
    bit    hold;
    bit    ready_m;
    word_t w;
    if (rst) begin
      chk("rst_in_ready", a_if.in_ready, 0);
      exp_q.delete();
      acc   = '0;
      acc_n = 0;
    end else begin
      hold    = (exp_q.size() != 0);
      ready_m = hold ? a_if.out_ready : 1'b1;
      chk("out_valid", a_if.out_valid, hold);
      chk("in_ready", a_if.in_ready, ready_m);
      if (hold) begin
        chk("out_data", a_if.out_data, exp_q[0].d);
        chk("out_cnt", a_if.out_cnt, exp_q[0].cnt);
        chk("out_last", a_if.out_last, exp_q[0].last);
        if (a_if.out_ready) begin
          w = exp_q.pop_front();
          n_out++;
        end
      end
      if (a_if.in_valid && ready_m) begin
        acc = acc | (DW'(a_if.in_data) << (W * acc_n));
        acc_n++;
        if (acc_n == R || (FLUSH && a_if.in_last)) begin
          w.d    = acc;
          w.cnt  = acc_n;
          w.last = FLUSH && a_if.in_last;
          exp_q.push_back(w);
          acc   = '0;
          acc_n = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    a_if.in_valid = 1'b0;
    a_if.in_last  = 1'b0;
    repeat (n) step();
  endtask

  // Offer one word and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] d, input logic l, input bit expect_ready);
    int t;
    t = 0;
    a_if.in_valid = 1'b1;
    a_if.in_data  = d;
    a_if.in_last  = l;
    @(negedge clk);
    if (expect_ready) chk("stream_ready", a_if.in_ready, 1);
    while (!a_if.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 0, 1);
    step();
    a_if.in_valid = 1'b0;
    a_if.in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_last = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_last = 1'b0; b_if.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("rst_ready_a", a_if.in_ready, 0);
    chk("rst_ready_b", b_if.in_ready, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", a_if.out_valid, 0);
    chk("rst_data", a_if.out_data, 0);
    chk("rst_cnt", a_if.out_cnt, 0);
    chk("rst_last", a_if.out_last, 0);
    step();

    // Basic pack with one-cycle latency
    a_if.out_ready = 1'b1;
    send(8'h11, 0, 1); send(8'h22, 0, 1); send(8'h33, 0, 1);
    a_if.in_valid = 1'b1;
    a_if.in_data  = 8'h44;
    @(negedge clk);
    chk("basic_pre_valid", a_if.out_valid, 0);
    step();
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("basic_valid", a_if.out_valid, 1);
    chk("basic_data", a_if.out_data, 32'h4433_2211);
    chk("basic_cnt", a_if.out_cnt, 4);
    chk("basic_last", a_if.out_last, 0);
    step();
    idle(2);

    // Back-to-back streaming
    for (int i = 1; i <= 8; i++) send(W'(i), 0, 1);
    idle(3);

    // Backpressure while a word is held
    a_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(W'(8'hA1 + i), 0, 1);
    a_if.in_valid = 1'b1;
    a_if.in_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", a_if.in_ready, 0);
      chk("stall_data", a_if.out_data, 32'hA4A3_A2A1);
      step();
    end
    a_if.out_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", a_if.in_ready, 1);
    step();
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("release_valid", a_if.out_valid, 0);
    chk("release_slot0", a_if.out_data, 32'h0000_0055);
    step();
    send(8'h66, 0, 1); send(8'h77, 0, 1); send(8'h88, 0, 1);
    @(negedge clk);
    chk("release_word", a_if.out_data, 32'h8877_6655);
    step();
    idle(2);

    // Early completion on in_last
    send(8'hAA, 0, 1);
    send(8'hBB, 1, 1);
    @(negedge clk);
`ifdef CHAN_PACKER_FLUSH_EN
    chk("flush_valid", a_if.out_valid, 1);
    chk("flush_data", a_if.out_data, 32'h0000_BBAA);
    chk("flush_cnt", a_if.out_cnt, 2);
    chk("flush_last", a_if.out_last, 1);
    step();
    idle(2);
`else
    chk("noflush_valid", a_if.out_valid, 0);
    step();
    send(8'hCC, 0, 1);
    send(8'hDD, 0, 1);
    idle(2);
`endif

    // Reset while holding a word
    a_if.out_ready = 1'b0;
    send(8'h11, 0, 1); send(8'h22, 0, 1); send(8'h33, 0, 1); send(8'h44, 0, 1);
    @(negedge clk);
    chk("prerst_valid", a_if.out_valid, 1);
    chk("prerst_data", a_if.out_data, 32'h4433_2211);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_valid", a_if.out_valid, 0);
    chk("postrst_data", a_if.out_data, 0);
    step();
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(W'($urandom), 0, 1);
    idle(2);

    // Ratio of one: every input is its own output word
    b_if.out_ready = 1'b1;
    b_if.in_valid  = 1'b1;
    b_if.in_data   = 8'h5A;
    step();
    b_if.in_data = 8'hA5;
    @(negedge clk);
    chk("r1_valid0", b_if.out_valid, 1);
    chk("r1_data0", b_if.out_data, 8'h5A);
    chk("r1_cnt0", b_if.out_cnt, 1);
    chk("r1_ready", b_if.in_ready, 1);
    step();
    b_if.in_valid = 1'b0;
    @(negedge clk);
    chk("r1_valid1", b_if.out_valid, 1);
    chk("r1_data1", b_if.out_data, 8'hA5);
    chk("r1_cnt1", b_if.out_cnt, 1);
    step();
    @(negedge clk);
    chk("r1_drained", b_if.out_valid, 0);
    step();

    // Randomized traffic against the scoreboard
    repeat (400) begin
      a_if.in_valid  = ($urandom % 10) < 7;
      a_if.in_data   = W'($urandom);
      a_if.in_last   = ($urandom % 5) == 0;
      a_if.out_ready = ($urandom % 10) < 6;
      rst            = ($urandom % 100) == 0;
      step();
    end
    rst = 1'b0;
    a_if.out_ready = 1'b1;
    idle(4);
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    chk("sb_enough_words", n_out > 20, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
